// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction class codes, per-class cycle budgets
// and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int unsigned CLS_W  = 2;
  localparam int unsigned HOLD_W = 3;

  localparam logic [CLS_W-1:0] CLS_HALT  = 2'b00;
  localparam logic [CLS_W-1:0] CLS_STD   = 2'b01;
  localparam logic [CLS_W-1:0] CLS_LOAD  = 2'b10;
  localparam logic [CLS_W-1:0] CLS_STORE = 2'b11;

  // Control unit FSM path lengths per instruction class
  localparam logic [HOLD_W-1:0] BUDGET_STD   = 3'd3;
  localparam logic [HOLD_W-1:0] BUDGET_LOAD  = 3'd4;
  localparam logic [HOLD_W-1:0] BUDGET_STORE = 3'd3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_PRIME = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_state_e;

  // Cycles an instruction must stay on the bus; first adds the RESET->DECODE step
  function automatic logic [HOLD_W-1:0] budget(input logic [CLS_W-1:0] cls,
                                               input logic             first);
    logic [HOLD_W-1:0] b;
    case (cls)
      CLS_STD:   b = BUDGET_STD;
      CLS_LOAD:  b = BUDGET_LOAD;
      CLS_STORE: b = BUDGET_STORE;
      default:   b = '0;
    endcase
    if (first && (b != '0)) b = b + HOLD_W'(1);
    return b;
  endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: primes the first word from a synchronous ROM,
// holds each instruction for its class budget and prefetches the next word so
// it lands exactly when the control unit returns to DECODE.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PC_BITS     = 5,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   imem_rd,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output logic [7:0]             retired_count
);

  if ((MEM_LATENCY != 1) && (MEM_LATENCY != 2)) begin : g_bad_latency
    $error("instr_fetch_seq: MEM_LATENCY must be 1 or 2");
  end

  localparam logic [HOLD_W-1:0] PREFETCH_AT = HOLD_W'(MEM_LATENCY + 1);

  seq_state_e             state, state_d;
  logic [HOLD_W-1:0]      hold_cnt, hold_d;
  logic                   first_flag, first_d;
  logic [PC_BITS-1:0]     pc_d, addr_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [7:0]             retired_d;
  logic                   rd_d;
  logic [CLS_W-1:0]       data_cls;

  assign data_cls = imem_data[INSTR_WIDTH-1 -: CLS_W];

  // Next-state and registered-output values
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    first_d   = first_flag;
    pc_d      = pc;
    instr_d   = instr;
    retired_d = retired_count;
    addr_d    = imem_addr;
    rd_d      = 1'b0;

    case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_PRIME;
          hold_d  = PREFETCH_AT;
          rd_d    = 1'b1;
          addr_d  = pc;
        end
      end
      SEQ_PRIME: begin
        if (hold_cnt == HOLD_W'(1)) begin
          instr_d = imem_data;
          if (data_cls == CLS_HALT) begin
            state_d = SEQ_HALT;
          end else begin
            state_d = SEQ_RUN;
            hold_d  = budget(data_cls, first_flag);
            first_d = 1'b0;
          end
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      SEQ_RUN: begin
        if (hold_cnt == HOLD_W'(1)) begin
          instr_d   = imem_data;
          pc_d      = pc + PC_BITS'(1);
          retired_d = retired_count + 8'd1;
          if (data_cls == CLS_HALT) state_d = SEQ_HALT;
          else                      hold_d  = budget(data_cls, first_flag);
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      default: ;
    endcase

    // Prefetch strobe lands MEM_LATENCY+1 cycles before the hold expires
    if ((state_d == SEQ_RUN) && (hold_d == PREFETCH_AT)) begin
      rd_d   = 1'b1;
      addr_d = pc_d + PC_BITS'(1);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEQ_IDLE;
      hold_cnt      <= '0;
      first_flag    <= 1'b1;
      pc            <= '0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      imem_rd       <= 1'b0;
      imem_addr     <= '0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_d;
      first_flag    <= first_d;
      pc            <= pc_d;
      instr         <= instr_d;
      instr_valid   <= (state_d == SEQ_RUN);
      imem_rd       <= rd_d;
      imem_addr     <= addr_d;
      busy          <= (state_d == SEQ_PRIME) || (state_d == SEQ_RUN);
      halted        <= (state_d == SEQ_HALT);
      retired_count <= retired_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: one instance per legal ROM latency,
// each fed by its own ROM model sharing one program image.
module tb_instr_fetch_seq;

  logic clk, rst, start;

  logic        rd1, rd2;
  logic [4:0]  addr1, addr2, pc1, pc2;
  logic [19:0] q1, q2a, q2b, instr1, instr2;
  logic        valid1, valid2, busy1, busy2, halted1, halted2;
  logic [7:0]  ret1, ret2;

  logic [19:0] rom [32];

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_seq #(.INSTR_WIDTH(20), .PC_BITS(5), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .imem_rd(rd1), .imem_addr(addr1),
    .imem_data(q1), .instr(instr1), .instr_valid(valid1), .pc(pc1),
    .busy(busy1), .halted(halted1), .retired_count(ret1));

  instr_fetch_seq #(.INSTR_WIDTH(20), .PC_BITS(5), .MEM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .imem_rd(rd2), .imem_addr(addr2),
    .imem_data(q2b), .instr(instr2), .instr_valid(valid2), .pc(pc2),
    .busy(busy2), .halted(halted2), .retired_count(ret2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: one and two cycle read latency
  always @(posedge clk) begin
    if (rd1) q1 <= rom[addr1];
  end
  always @(posedge clk) begin
    if (rd2) q2a <= rom[addr2];
    q2b <= q2a;
  end

  typedef struct {
    logic        rst, start;
    logic [19:0] instr;
    logic        valid;
    logic [4:0]  pc;
    logic        busy, halted;
    logic [7:0]  ret;
    logic        rd;
    logic [4:0]  addr;
    logic [19:0] instr2;
    logic        rd2, halted2;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r, s, input logic [19:0] i, input logic v,
                              input logic [4:0] p, input logic b, h, input logic [7:0] rc,
                              input logic rd, input logic [4:0] a, input logic [19:0] i2,
                              input logic rdb, hb);
    vec_t x;
    x.rst = r; x.start = s; x.instr = i; x.valid = v; x.pc = p; x.busy = b;
    x.halted = h; x.ret = rc; x.rd = rd; x.addr = a; x.instr2 = i2;
    x.rd2 = rdb; x.halted2 = hb;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},     32'(pc1), 0);
    chk({tag, ".instr"},  32'(instr1), 0);
    chk({tag, ".valid"},  32'(valid1), 0);
    chk({tag, ".rd"},     32'(rd1), 0);
    chk({tag, ".addr"},   32'(addr1), 0);
    chk({tag, ".halted"}, 32'(halted1), 0);
    chk({tag, ".ret"},    32'(ret1), 0);
    chk({tag, ".busy"},   32'(busy1), 0);
    chk({tag, ".busy2"},  32'(busy2), 0);
    chk({tag, ".pc2"},    32'(pc2), 0);
  endtask

  int cnt, t40a, t40b;
  logic [4:0] pc40a, pc40b, pc771, wrap_addr;
  logic [7:0] ret770, ret771;
  logic busy_low, dbl_rd, wrap_seen, prev1, prev2;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 20'h0;
    rom[0] = 20'h41230; rom[1] = 20'h9A050; rom[2] = 20'hE1070; rom[3] = 20'h00000;

    //            r  s  instr     v  pc  b  h  ret  rd addr instr2   rd2 h2
    tbl[0]  = mk(1, 0, 20'h0,     0, 0,  0, 0, 0,   0, 0,   20'h0,     0, 0);
    tbl[1]  = mk(1, 0, 20'h0,     0, 0,  0, 0, 0,   0, 0,   20'h0,     0, 0);
    tbl[2]  = mk(0, 1, 20'h0,     0, 0,  1, 0, 0,   1, 0,   20'h0,     1, 0);
    tbl[3]  = mk(0, 0, 20'h0,     0, 0,  1, 0, 0,   0, 0,   20'h0,     0, 0);
    tbl[4]  = mk(0, 0, 20'h41230, 1, 0,  1, 0, 0,   0, 0,   20'h0,     0, 0);
    tbl[5]  = mk(0, 0, 20'h41230, 1, 0,  1, 0, 0,   0, 0,   20'h41230, 0, 0);
    tbl[6]  = mk(0, 0, 20'h41230, 1, 0,  1, 0, 0,   1, 1,   20'h41230, 1, 0);
    tbl[7]  = mk(0, 0, 20'h41230, 1, 0,  1, 0, 0,   0, 1,   20'h41230, 0, 0);
    tbl[8]  = mk(0, 0, 20'h9A050, 1, 1,  1, 0, 1,   0, 1,   20'h41230, 0, 0);
    tbl[9]  = mk(0, 0, 20'h9A050, 1, 1,  1, 0, 1,   0, 1,   20'h9A050, 0, 0);
    tbl[10] = mk(0, 0, 20'h9A050, 1, 1,  1, 0, 1,   1, 2,   20'h9A050, 1, 0);
    tbl[11] = mk(0, 0, 20'h9A050, 1, 1,  1, 0, 1,   0, 2,   20'h9A050, 0, 0);
    tbl[12] = mk(0, 0, 20'hE1070, 1, 2,  1, 0, 2,   0, 2,   20'h9A050, 0, 0);
    tbl[13] = mk(0, 0, 20'hE1070, 1, 2,  1, 0, 2,   1, 3,   20'hE1070, 1, 0);
    tbl[14] = mk(0, 0, 20'hE1070, 1, 2,  1, 0, 2,   0, 3,   20'hE1070, 0, 0);
    tbl[15] = mk(0, 0, 20'h0,     0, 3,  0, 1, 3,   0, 3,   20'hE1070, 0, 0);
    tbl[16] = mk(0, 0, 20'h0,     0, 3,  0, 1, 3,   0, 3,   20'h0,     0, 1);
    tbl[17] = mk(0, 1, 20'h0,     0, 3,  0, 1, 3,   0, 3,   20'h0,     0, 1);

    // Four-word program, both latencies, start pulse in HALT on the last row
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst;
      start = tbl[i].start;
      tick();
      chk($sformatf("row%0d.instr", i),   32'(instr1),  32'(tbl[i].instr));
      chk($sformatf("row%0d.valid", i),   32'(valid1),  32'(tbl[i].valid));
      chk($sformatf("row%0d.pc", i),      32'(pc1),     32'(tbl[i].pc));
      chk($sformatf("row%0d.busy", i),    32'(busy1),   32'(tbl[i].busy));
      chk($sformatf("row%0d.halted", i),  32'(halted1), 32'(tbl[i].halted));
      chk($sformatf("row%0d.ret", i),     32'(ret1),    32'(tbl[i].ret));
      chk($sformatf("row%0d.rd", i),      32'(rd1),     32'(tbl[i].rd));
      chk($sformatf("row%0d.addr", i),    32'(addr1),   32'(tbl[i].addr));
      chk($sformatf("row%0d.instr2", i),  32'(instr2),  32'(tbl[i].instr2));
      chk($sformatf("row%0d.rd2", i),     32'(rd2),     32'(tbl[i].rd2));
      chk($sformatf("row%0d.halted2", i), 32'(halted2), 32'(tbl[i].halted2));
    end
    start = 1'b0;

    // Reset held two cycles in the middle of RUN
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("A.valid_before_rst", 32'(valid1), 1);
    rst = 1'b1; tick(); tick();
    chk_reset("A.in_rst");
    rst = 1'b0; tick();
    chk_reset("A.after_rst");

    // Single instruction followed by halt
    for (int i = 0; i < 32; i++) rom[i] = 20'h0;
    rom[0] = 20'h41230;
    start = 1'b1; tick(); start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (valid1 && (instr1 == 20'h41230)) cnt++;
      if (halted1 && halted2) break;
    end
    chk("B.hold_cycles", 32'(cnt), 4);
    chk("B.ret",    32'(ret1), 1);
    chk("B.pc",     32'(pc1), 1);
    chk("B.halted", 32'(halted1), 1);
    chk("B.valid",  32'(valid1), 0);
    chk("B.instr",  32'(instr1), 0);
    chk("B.busy",   32'(busy1), 0);
    chk("B.ret2",   32'(ret2), 1);
    chk("B.pc2",    32'(pc2), 1);

    // Endless std_op stream: pc wrap, retired wrap, start pulse mid-RUN
    for (int i = 0; i < 32; i++) rom[i] = 20'h40000;
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    busy_low = 1'b0; dbl_rd = 1'b0; wrap_seen = 1'b0; wrap_addr = 5'h1f;
    t40a = -1; t40b = -1; pc40a = 5'h1f; pc40b = 5'h1f;
    ret770 = 8'h0; ret771 = 8'hff; pc771 = 5'h1f;
    prev1 = rd1; prev2 = rd2;
    for (int n = 1; n <= 775; n++) begin
      start = (n == 10);
      tick();
      if (!busy1 || !busy2) busy_low = 1'b1;
      if ((prev1 && rd1) || (prev2 && rd2)) dbl_rd = 1'b1;
      prev1 = rd1; prev2 = rd2;
      if (rd1 && (pc1 == 5'd31) && !wrap_seen) begin
        wrap_seen = 1'b1;
        wrap_addr = addr1;
      end
      if ((ret1 == 8'd40) && (t40a < 0)) begin t40a = n; pc40a = pc1; end
      if ((ret2 == 8'd40) && (t40b < 0)) begin t40b = n; pc40b = pc2; end
      if (n == 770) ret770 = ret1;
      if (n == 771) begin ret771 = ret1; pc771 = pc1; end
    end
    start = 1'b0;
    chk("C.busy_held",   32'(busy_low), 0);
    chk("C.rd_single",   32'(dbl_rd), 0);
    chk("C.wrap_seen",   32'(wrap_seen), 1);
    chk("C.wrap_addr",   32'(wrap_addr), 0);
    chk("C.t40",         32'(t40a), 123);
    chk("C.pc40",        32'(pc40a), 8);
    chk("C.t40_lat2",    32'(t40b), 124);
    chk("C.pc40_lat2",   32'(pc40b), 8);
    chk("C.ret_255",     32'(ret770), 255);
    chk("C.ret_wrap",    32'(ret771), 0);
    chk("C.pc_at_wrap",  32'(pc771), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
